wb_regfile: RTL

- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Each valid cycle, selects either the load data (with byte/half extraction and extension) or the ALU result.
- Commits the selected value to a 32x32 general register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Also maintains a retired-writeback counter for performance monitoring.

---
 rtl/wb_regfile.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage register file: selects load data (byte/half/word extract + extend) or ALU result,
// commits it to a 32x32 GPR array and serves two combinational read ports with same-cycle bypass.
// Latency: write data is combinational into the write path and visible in storage the next cycle;
// wb_*_out and retired_cnt are registered one cycle after the commit edge.
// Backpressure: none. One entry is accepted every cycle and the stage never stalls.
//
// Ports:
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   wb_valid, wb_reg_write         entry is real / entry writes a register
//   wb_mem_to_reg                  1 = load data, 0 = ALU result
//   wb_mem_size, wb_mem_signed     load size (00 b, 01 h, 1x word) and sign-extend select
//   mem_data_in, alu_result_in     raw memory word; ALU result (bits [1:0] = load byte offset)
//   reg_dest_in                    destination index, only low index bits used
//   rs_addr/rs_data, rt_addr/rt_data   ID-stage read ports
//   wb_we_out, wb_addr_out, wb_data_out  registered commit for the hazard unit
//   retired_cnt                    count of committed register writes (wraps)
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  input  logic                    wb_reg_write,
  input  logic                    wb_mem_to_reg,
  input  logic [1:0]              wb_mem_size,
  input  logic                    wb_mem_signed,
  input  logic [DW-1:0]           mem_data_in,
  input  logic [DW-1:0]           alu_result_in,
  input  logic [31:0]             reg_dest_in,
  input  logic [$clog2(NREG)-1:0] rs_addr,
  input  logic [$clog2(NREG)-1:0] rt_addr,
  output logic [DW-1:0]           rs_data,
  output logic [DW-1:0]           rt_data,
  output logic                    wb_we_out,
  output logic [$clog2(NREG)-1:0] wb_addr_out,
  output logic [DW-1:0]           wb_data_out,
  output logic [CNT_W-1:0]        retired_cnt
);

  localparam int AW = $clog2(NREG);

  logic [AW-1:0]    dest;
  logic             commit;
  logic [1:0]       off;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [DW-1:0]    load_ext;
  logic [DW-1:0]    wdata;

  logic [DW-1:0]    regs_q [NREG];
  logic [DW-1:0]    regs_d [NREG];
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Upper destination bits carry no meaning here; fold them so they are visibly consumed.
  logic unused_dest_bits;
  assign unused_dest_bits = ^reg_dest_in[31:AW];

  assign dest   = reg_dest_in[AW-1:0];
  // Index 0 is hard-wired zero, so a write to it is not a commit at all (no write, no count).
  assign commit = wb_valid & wb_reg_write & (dest != '0);

  // Little-endian sub-word extraction. For halves only off[1] matters; a misaligned
  // half simply takes the half that contains the addressed byte.
  always_comb begin
    off      = alu_result_in[1:0];
    byte_sel = mem_data_in[{off, 3'b000} +: 8];
    half_sel = mem_data_in[{off[1], 4'b0000} +: 16];
    load_ext = mem_data_in;
    case (wb_mem_size)
      2'b00:   load_ext = {{(DW-8){wb_mem_signed & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{(DW-16){wb_mem_signed & half_sel[15]}}, half_sel};
      default: load_ext = mem_data_in;  // word, and the reserved encoding
    endcase
    wdata = wb_mem_to_reg ? load_ext : alu_result_in;
  end

  // Read ports: zero register, then same-cycle bypass of the value being committed, then storage.
  // The bypass is independent of rst, so reads still see the in-flight value during reset.
  always_comb begin
    if (rs_addr == '0)                  rs_data = '0;
    else if (commit && rs_addr == dest) rs_data = wdata;
    else                                rs_data = regs_q[rs_addr];

    if (rt_addr == '0)                  rt_data = '0;
    else if (commit && rt_addr == dest) rt_data = wdata;
    else                                rt_data = regs_q[rt_addr];
  end

  // Next-state: reset takes priority so a commit in the reset cycle is dropped entirely.
  always_comb begin
    regs_d = regs_q;
    we_d   = commit;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_d[i] = '0;
      we_d   = 1'b0;
      addr_d = '0;
      data_d = '0;
      cnt_d  = '0;
    end else if (commit) begin
      regs_d[dest] = wdata;
      addr_d       = dest;
      data_d       = wdata;
      cnt_d        = cnt_q + CNT_W'(1);  // wraps naturally at 2^CNT_W
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    we_q   <= we_d;
    addr_q <= addr_d;
    data_q <= data_d;
    cnt_q  <= cnt_d;
  end

  assign wb_we_out   = we_q;
  assign wb_addr_out = addr_q;
  assign wb_data_out = data_q;
  assign retired_cnt = cnt_q;

endmodule
